// File: rtl/cfg_seq_pkg.sv
// Shared definitions for the configuration-chain sequencer: register
// indices, CTRL/STATUS bit positions and the sequencer state encoding.
package cfg_seq_pkg;

  localparam int WORD_W = 32;

  // Register index taken from wb_adr_i[3:2] (byte offsets 0x0/0x4/0x8/0xC).
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_LEN    = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  // STATUS bits
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_LVL_LSB = 4;
  localparam int STAT_LVL_W   = 4;
  localparam int STAT_OVF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_SET   = 2'd3
  } state_t;

endpackage

// File: rtl/cfg_seq_fifo.sv
// Small synchronous FIFO for config words. Combinational read of the head
// entry, level counter that saturates at DEPTH, synchronous flush.
module cfg_seq_fifo
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [W-1:0]  o_rdata,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Word storage.
  // NOTE: the storage array has no reset; only pointers and level define
  // which entries are valid, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap modulo DEPTH (power of two); level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cfg_chain_sequencer.sv
// Wishbone slave that buffers config words and serialises them LSB-first
// onto the fabric config chain, followed by a latch strobe and an IRQ pulse.
module cfg_chain_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int SET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        cfg_en_o,
  output logic        cfg_data_o,
  output logic        cfg_set_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int SC_W = $clog2(SET_CYCLES + 1);

  // Bus side
  logic              r_ack;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_len;
  logic              r_ovf;
  logic              r_done;
  logic              w_acc;
  logic              w_wr;
  logic [1:0]        w_reg;
  logic [31:0]       w_status;
  logic [31:0]       w_rd_mux;
  logic              w_start;
  logic              w_abort;
  logic              w_unused;

  // Sequencer side
  state_t            r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [WORD_W-1:0] r_shreg;
  logic [5:0]        r_wbits;
  logic [SC_W-1:0]   r_set_cnt;
  logic              r_cfg_en;
  logic              r_cfg_data;
  logic              r_cfg_set;
  logic              r_irq;
  logic              w_busy;
  logic              w_done_set;

  // FIFO
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_fifo_rdata;
  logic [LW-1:0]     w_level;
  logic              w_full;
  logic              w_empty;

  assign w_acc    = wb_cyc_i && wb_stb_i && !r_ack;
  assign w_wr     = w_acc && wb_we_i;
  assign w_reg    = wb_adr_i[3:2];
  assign w_unused = ^wb_adr_i[1:0];
  assign w_busy   = (r_state != ST_IDLE);

  assign w_abort  = w_wr && (w_reg == ADR_CTRL) && wb_dat_i[CTRL_ABORT];
  assign w_start  = w_wr && (w_reg == ADR_CTRL) && wb_dat_i[CTRL_START] && !wb_dat_i[CTRL_ABORT];
  assign w_push   = w_wr && (w_reg == ADR_DATA) && !w_full;
  assign w_pop    = (r_state == ST_LOAD) && !w_empty && !w_abort;

  assign w_done_set = (r_state == ST_SET) && (r_set_cnt == '0) && !w_abort;

  cfg_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (wb_dat_i),
    .i_pop   (w_pop),
    .i_flush (w_abort),
    .o_rdata (w_fifo_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Status word assembly and read-data selection.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_status                                = '0;
    w_status[STAT_BUSY]                     = w_busy;
    w_status[STAT_DONE]                     = r_done;
    w_status[STAT_LVL_LSB +: STAT_LVL_W]    = STAT_LVL_W'(w_level);
    w_status[STAT_OVF]                      = r_ovf;
    w_rd_mux = '0;
    case (w_reg)
      ADR_LEN:    w_rd_mux = 32'(r_len);
      ADR_STATUS: w_rd_mux = w_status;
      default:    w_rd_mux = '0;
    endcase
  end

  // Wishbone ack/read data and register write side effects, all on the ack edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && !wb_we_i) ? w_rd_mux : '0;
      if (w_wr && (w_reg == ADR_DATA) && w_full) r_ovf <= 1'b1;
      if (w_wr && (w_reg == ADR_LEN) && !w_busy) r_len <= wb_dat_i[CNT_W-1:0];
      if (w_wr && (w_reg == ADR_STATUS)) begin
        if (wb_dat_i[STAT_OVF])  r_ovf  <= 1'b0;
        if (wb_dat_i[STAT_DONE]) r_done <= 1'b0;
      end
      // Completion beats a simultaneous W1C so a finished load is never lost.
      if (w_done_set) r_done <= 1'b1;
    end
  end

  // Sequencer FSM with registered chain outputs. r_shreg holds the bits not
  // yet driven; the bit on cfg_data_o has already been shifted out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_shreg    <= '0;
      r_wbits    <= '0;
      r_set_cnt  <= '0;
      r_cfg_en   <= 1'b0;
      r_cfg_data <= 1'b0;
      r_cfg_set  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_cfg_en   <= 1'b0;
        r_cfg_data <= 1'b0;
        r_cfg_set  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start && (r_len != '0)) begin
              r_state <= ST_LOAD;
              r_rem   <= r_len;
            end
          end
          ST_LOAD: begin
            if (!w_empty) begin
              r_shreg    <= w_fifo_rdata >> 1;
              r_cfg_data <= w_fifo_rdata[0];
              r_cfg_en   <= 1'b1;
              r_wbits    <= 6'd32;
              r_state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            r_shreg <= r_shreg >> 1;
            r_rem   <= r_rem - 1'b1;
            r_wbits <= r_wbits - 1'b1;
            if (r_rem == CNT_W'(1)) begin
              r_state    <= ST_SET;
              r_cfg_en   <= 1'b0;
              r_cfg_data <= 1'b0;
              r_cfg_set  <= 1'b1;
              r_set_cnt  <= SC_W'(SET_CYCLES - 1);
            end else if (r_wbits == 6'd1) begin
              r_state    <= ST_LOAD;
              r_cfg_en   <= 1'b0;
              r_cfg_data <= 1'b0;
            end else begin
              r_cfg_data <= r_shreg[0];
            end
          end
          ST_SET: begin
            if (r_set_cnt == '0) begin
              r_state   <= ST_IDLE;
              r_cfg_set <= 1'b0;
              r_irq     <= 1'b1;
            end else begin
              r_set_cnt <= r_set_cnt - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_rdata;
  assign cfg_en_o   = r_cfg_en;
  assign cfg_data_o = r_cfg_data;
  assign cfg_set_o  = r_cfg_set;
  assign busy_o     = w_busy;
  assign irq_o      = r_irq;

endmodule
